// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory read port plus the decode handshake.
// master = fetch_queue, slave = memory/decode side.
interface fetch_queue_if #(
    parameter int IMEM_AW = 11
);
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_rden;
    logic [31:0]        imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_inst;
    logic [31:0]        out_pc;
    logic [31:0]        out_npc;

    modport master (
        output imem_addr,
        output imem_rden,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        output out_npc
    );

    modport slave (
        input  imem_addr,
        input  imem_rden,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        input  out_npc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential reads into a prefetch queue,
// with redirect flush and a valid/ready handoff to decode.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 11,
    parameter int          QDEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_valid_i,
    input  logic [31:0]   redirect_pc_i,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_RESET,
        S_INIT,
        S_RUN
    } state_e;

    state_e         state_q;
    logic [31:0]    fetch_pc_q;
    logic [31:0]    fetch_pc_d;
    logic [31:0]    rd_pc_q;
    logic           inflight_q;
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  head_d;
    logic [PW-1:0]  tail_q;
    logic [PW-1:0]  tail_d;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic [31:0]    inst_q [QDEPTH];
    logic [31:0]    pc_q   [QDEPTH];

    logic           flush;
    logic           issue;
    logic           push;
    logic           pop;
    logic           valid;
    logic [CW:0]    occ;

    always_comb begin
        occ   = {1'b0, count_q} + (CW+1)'(inflight_q);
        valid = !rst && (count_q != '0);
        flush = !rst && redirect_valid_i && (state_q != S_RESET);
        issue = !rst && (state_q == S_RUN) && !redirect_valid_i
              && (occ < (CW+1)'(QDEPTH));
        // A redirect kills the read issued last cycle.
        push  = !rst && inflight_q && !flush;
        pop   = valid && bus.out_ready;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (flush) begin
            fetch_pc_d = redirect_pc_i & ~32'h3;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RESET;
            fetch_pc_q <= RESET_PC;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            unique case (state_q)
                S_RESET: state_q <= S_INIT;
                S_INIT:  state_q <= S_RUN;
                S_RUN:   state_q <= S_RUN;
                default: state_q <= S_RESET;
            endcase
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            if (issue) begin
                rd_pc_q <= fetch_pc_q;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[tail_q] <= bus.imem_rdata;
            pc_q[tail_q]   <= rd_pc_q;
        end
    end

    assign bus.imem_addr = fetch_pc_q[IMEM_AW+1:2];
    assign bus.imem_rden = issue;
    assign bus.out_valid = valid;
    assign bus.out_inst  = valid ? inst_q[head_q] : 32'h0;
    assign bus.out_pc    = valid ? pc_q[head_q] : 32'h0;
    assign bus.out_npc   = valid ? pc_q[head_q] + 32'd4 : 32'h0;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed latency/redirect/wrap cases plus
// randomized traffic checked against a PC-stream reference model.
module tb_fetch_queue;
    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1;
    logic        rst1 = 1'b1;
    logic        rst1_nxt = 1'b1;
    logic        rv = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        rv1 = 1'b0;
    logic [31:0] rpc1 = 32'h0;

    always #5 clk = ~clk;

    fetch_queue_if #(.IMEM_AW(11)) b0();
    fetch_queue_if #(.IMEM_AW(4))  b1();

    fetch_queue #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (11),
        .QDEPTH   (QD)
    ) dut0 (
        .clk              (clk),
        .rst              (rst0),
        .redirect_valid_i (rv),
        .redirect_pc_i    (rpc),
        .bus              (b0.master)
    );

    fetch_queue #(
        .RESET_PC (32'hFFFF_FFF8),
        .IMEM_AW  (4),
        .QDEPTH   (QD)
    ) dut1 (
        .clk              (clk),
        .rst              (rst1),
        .redirect_valid_i (rv1),
        .redirect_pc_i    (rpc1),
        .bus              (b1.master)
    );

    // Memory word k holds 32'h1000_0000 + k, one-cycle read latency.
    always @(posedge clk) begin
        if (b0.imem_rden) b0.imem_rdata <= 32'h1000_0000 + 32'(b0.imem_addr);
        if (b1.imem_rden) b1.imem_rdata <= 32'h1000_0000 + 32'(b1.imem_addr);
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_pc = 32'h0;
    int          occ = 0;
    logic        hold = 1'b0;
    logic [31:0] hold_pc = 32'h0;
    logic [31:0] hold_inst = 32'h0;
    int          nxfer = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word0(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'h0000_07FF);
    endfunction

    // Reference: the head must always be the next PC of the current stream.
    task automatic monitor();
        if (rst0) begin
            check("rst_valid", 32'(b0.out_valid), 0);
            check("rst_rden", 32'(b0.imem_rden), 0);
            exp_pc = 32'h0;
            occ    = 0;
            hold   = 1'b0;
            return;
        end
        if (hold) begin
            check("hold_valid", 32'(b0.out_valid), 1);
            check("hold_pc", b0.out_pc, hold_pc);
            check("hold_inst", b0.out_inst, hold_inst);
        end
        if (b0.out_valid) begin
            check("pc", b0.out_pc, exp_pc);
            check("inst", b0.out_inst, word0(b0.out_pc));
            check("npc", b0.out_npc, b0.out_pc + 32'd4);
        end
        if (b0.imem_rden) check("occ_lim", 32'(occ < QD), 1);
        if (b0.out_valid && b0.out_ready) begin
            exp_pc = exp_pc + 32'd4;
            occ--;
            nxfer++;
        end
        if (rv) begin
            check("rv_rden", 32'(b0.imem_rden), 0);
            exp_pc = rpc & ~32'h3;
            occ    = 0;
        end else if (b0.imem_rden) begin
            occ++;
        end
        hold      = b0.out_valid && !b0.out_ready && !rv;
        hold_pc   = b0.out_pc;
        hold_inst = b0.out_inst;
    endtask

    task automatic cycle(input logic r, input logic rdy, input logic v,
                         input logic [31:0] pc);
        @(negedge clk);
        rst0         = r;
        rst1         = rst1_nxt;
        b0.out_ready = rdy;
        rv           = v;
        rpc          = pc;
        #1;
        monitor();
    endtask

    task automatic start0(input int n);
        repeat (n) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s0_valid", 32'(b0.out_valid), 0);
        check("s0_pc", b0.out_pc, 0);
        check("s0_inst", b0.out_inst, 0);
        check("s0_npc", b0.out_npc, 0);
        check("s0_rden", 32'(b0.imem_rden), 0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s0_init_rden", 32'(b0.imem_rden), 0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s0_first_rden", 32'(b0.imem_rden), 1);
        check("s0_first_addr", 32'(b0.imem_addr), 0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s0_e3_valid", 32'(b0.out_valid), 0);
        check("s0_e3_addr", 32'(b0.imem_addr), 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            check("s0_stream_valid", 32'(b0.out_valid), 1);
            check("s0_stream_pc", b0.out_pc, 32'(4 * i));
        end
    endtask

    task automatic start1(input int n);
        b1.out_ready = 1'b1;
        rst1_nxt = 1'b1;
        repeat (n) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        rst1_nxt = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_valid", 32'(b1.out_valid), 0);
        check("s1_pc", b1.out_pc, 0);
        check("s1_rden", 32'(b1.imem_rden), 0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_init_rden", 32'(b1.imem_rden), 0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_rden", 32'(b1.imem_rden), 1);
        check("s1_addr_a", 32'(b1.imem_addr), 14);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_e3_valid", 32'(b1.out_valid), 0);
        check("s1_addr_b", 32'(b1.imem_addr), 15);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_v0", 32'(b1.out_valid), 1);
        check("s1_pc0", b1.out_pc, 32'hFFFF_FFF8);
        check("s1_inst0", b1.out_inst, 32'h1000_000E);
        check("s1_addr_c", 32'(b1.imem_addr), 0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_pc1", b1.out_pc, 32'hFFFF_FFFC);
        check("s1_inst1", b1.out_inst, 32'h1000_000F);
        check("s1_npc1", b1.out_npc, 32'h0000_0000);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_pc2", b1.out_pc, 32'h0000_0000);
        check("s1_inst2", b1.out_inst, 32'h1000_0000);
        check("s1_npc2", b1.out_npc, 32'h0000_0004);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int since;
        int base;
        b0.out_ready = 1'b1;
        b1.out_ready = 1'b1;

        start0(3);

        // Backpressure from the first valid cycle.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            found = b0.out_valid;
        end
        check("bp_first_valid", 32'(found), 1);
        for (int i = 1; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            if (i >= 3) check("bp_rden_off", 32'(b0.imem_rden), 0);
            check("bp_head_pc", b0.out_pc, 0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            check("bp_rel_valid", 32'(b0.out_valid), 1);
            check("bp_rel_pc", b0.out_pc, 32'(4 * i));
        end

        // Redirect while the head is at 0x20.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            b0.out_ready = 1'b1;
            rv = 1'b0;
            #1;
            if (b0.out_valid && b0.out_pc == 32'h20) begin
                rv = 1'b1;
                rpc = 32'h0000_0103;
                found = 1'b1;
                #1;
            end
            monitor();
        end
        check("rd_found", 32'(found), 1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("rd_t1_valid", 32'(b0.out_valid), 0);
        check("rd_t1_rden", 32'(b0.imem_rden), 1);
        check("rd_t1_addr", 32'(b0.imem_addr), 32'h40);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("rd_t2_valid", 32'(b0.out_valid), 0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("rd_t3_valid", 32'(b0.out_valid), 1);
        check("rd_t3_pc", b0.out_pc, 32'h100);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("rd_t4_pc", b0.out_pc, 32'h104);

        // Back-to-back redirects: the last one wins.
        cycle(1'b0, 1'b1, 1'b1, 32'h40);
        cycle(1'b0, 1'b1, 1'b1, 32'h80);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            found = b0.out_valid;
        end
        check("b2b_valid", 32'(found), 1);
        check("b2b_pc", b0.out_pc, 32'h80);

        // Fill, then alternate ready with the queue full.
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        base = nxfer;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b0, (i % 2) == 0, 1'b0, 32'h0);
            check("tog_valid", 32'(b0.out_valid), 1);
        end
        check("tog_xfers", 32'(nxfer - base), 12);

        // Parametrised instance: wrap, then a mid-run reset pulse.
        start1(3);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        start1(1);

        // Randomized traffic with redirects and reset pulses.
        since = 100;
        base = nxfer;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic rdy;
            logic v;
            r   = (since > 20) && ($urandom_range(199) == 0);
            rdy = ($urandom_range(3) != 0);
            v   = !r && (since >= 1) && ($urandom_range(24) == 0);
            cycle(r, rdy, v, $urandom);
            since = r ? 0 : since + 1;
        end
        check("rand_xfers", 32'(nxfer - base > 1000), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch stage with a prefetch queue, placed between the synchronous instruction memory (1-cycle read latency) and decode.
- Issues sequential word reads from a programmable reset vector.
- Buffers up to QDEPTH fetched instructions with their PCs and hands them to decode over a valid/ready handshake.
- Supports a redirect port (branch/jump) that flushes the queue and kills the in-flight read.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- IMEM_AW, 11, instruction-memory word-address width; imem_addr = fetch_pc[IMEM_AW+1:2].
- QDEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- imem_addr  out  IMEM_AW  word address to instruction memory
- imem_rden  out  1  read enable; rdata is valid in the cycle after rden=1
- imem_rdata  in  32  read data from instruction memory
- redirect_valid  in  1  load redirect_pc as the new fetch address, flush queue
- redirect_pc  in  32  redirect target; bits [1:0] are ignored (forced 0)
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts the head; a transfer occurs when out_valid && out_ready
- out_inst  out  32  instruction at queue head
- out_pc  out  32  PC of out_inst
- out_npc  out  32  out_pc + 4, modulo 2^32

Behaviour:
- Reset decision: reset rst, synchronous, active-high; clock clk.
- Reset values, while rst=1 and in the cycle after: state=RESET, fetch_pc=RESET_PC, queue count=0, inflight=0, imem_rden=0, out_valid=0. out_inst, out_pc and out_npc read 0.
- State machine:
  - RESET -> INIT on the first edge where rst=0.
  - INIT -> RUN unconditionally. INIT is a dead cycle with imem_rden=0.
  - RUN -> RUN.
  - rst=1 in any state -> RESET, which drops the queue and the in-flight read.
- Issue rule, RUN only:
  - imem_rden = (count + inflight < QDEPTH) && !redirect_valid.
  - When issuing, imem_addr = fetch_pc[IMEM_AW+1:2] and fetch_pc <= fetch_pc + 4 (wraps modulo 2^32).
  - Memory address wraps silently; upper PC bits are not checked.
- inflight: register equal to last cycle's imem_rden. A shadow register rd_pc holds the issued PC.
- Push: when inflight=1 and no kill, {imem_rdata, rd_pc} is written to the queue tail at the end of that cycle.
- Pop: a transfer pops the head. Push and pop may occur in the same cycle, count unchanged, including when count=QDEPTH. Overflow is impossible by the issue rule.
- Outputs: registered from queue storage. out_valid = (count != 0).
- Stability: while out_valid=1 and out_ready=0, the head contents are held stable.
- Latency from reset: first imem_rden in the cycle after the 2nd rising edge with rst=0. out_valid first high after the 4th edge, with out_pc=RESET_PC.
- Throughput: with out_ready held high and QDEPTH>=4, one instruction per cycle is sustained.
- Redirect (cycle t, any state except RESET):
  - count <= 0 and fetch_pc <= {redirect_pc[31:2],2'b00}.
  - The read issued at t-1 is killed: its data is not pushed at t.
  - No read is issued at t.
  - A transfer handshaked at t is considered accepted by decode.
  - Redirect target read issued at t+1; out_valid earliest after the edge ending t+2.
- Redirect in INIT: fetch_pc is updated and fetch starts from the target in RUN.
- Back-to-back redirects: the last one wins; each kills the prior in-flight read.
- rst asserted mid-operation: all entries and the in-flight read are discarded. Next fetch is RESET_PC per the latency above.

Test Plan:
- Reset/start: rst 1 for 3 cycles then 0, out_ready=1, memory word k = 32'h1000_0000+k -> out_valid after 4th edge; out_pc 0,4,8,12 on consecutive cycles; out_inst 1000_0000..1000_0003; out_npc = out_pc+4.
- Backpressure: out_ready=0 from first valid for 10 cycles -> count reaches 4 and imem_rden stays 0. Head is stable at pc=0. On release, pcs 0,4,8,12,16 with no gap or duplicate.
- Redirect: redirect_valid pulse with redirect_pc=32'h0000_0103 while streaming at pc=0x20 -> no pc 0x24/0x28 appears after the flush. Next delivered out_pc=0x100, then 0x104.
- Back-to-back redirects 0x40 then 0x80 in consecutive cycles -> first delivered out_pc=0x80; 0x40 never delivered.
- Simultaneous push/pop at full: QDEPTH=4 queue full, out_ready toggles 1/0 each cycle -> order preserved, no loss, count never exceeds 4.
- Parameters and wrap: RESET_PC=32'hFFFF_FFF8, IMEM_AW=4 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; imem_addr 14, 15, 0. Mid-run rst pulse -> restart at RESET_PC with the 4-edge latency.
